clock_set_ctrl: RTL and testbench

- Time-setting controller for the digital clock display path.
- Sequences user set mode from two debounced buttons, mode and inc.
- Holds an editable BCD copy of HH:MM and drives the display mux select, so the display shows either live time or the edited value.
- Issues a one-cycle load pulse that commits the edited value into the timekeeping counter. Blinks the field being edited.

---
 rtl/clock_pkg.sv | 23 ++
 rtl/bcd2_wrap_inc.sv | 27 ++
 rtl/clock_set_ctrl.sv | 157 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-setting path.
// Holds the set-mode state encoding, BCD digit width and the default limits.
package clock_pkg;

  localparam int DIGIT_W           = 4;
  localparam int HOUR_MAX_DEF      = 23;
  localparam int MIN_MAX_DEF       = 59;
  localparam int TIMEOUT_TICKS_DEF = 20;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  localparam int TO_W = cnt_width(TIMEOUT_TICKS_DEF);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/bcd2_wrap_inc.sv
// Two-digit BCD increment with wrap to 00 once the value is at or above max.
// Purely combinational; digits beyond max (bad captures) also wrap.
module bcd2_wrap_inc
  import clock_pkg::*;
(
  input  logic [DIGIT_W-1:0] tens,
  input  logic [DIGIT_W-1:0] ones,
  input  logic [DIGIT_W-1:0] max_tens,
  input  logic [DIGIT_W-1:0] max_ones,
  output logic [DIGIT_W-1:0] inc_tens,
  output logic [DIGIT_W-1:0] inc_ones
);

  always_comb begin
    inc_tens = tens;
    inc_ones = ones + DIGIT_W'(1);
    // Packed BCD compares in the same order as the decimal value
    if ({tens, ones} >= {max_tens, max_ones}) begin
      inc_tens = '0;
      inc_ones = '0;
    end else if (ones >= DIGIT_W'(9)) begin
      inc_tens = tens + DIGIT_W'(1);
      inc_ones = '0;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: mode/inc button sequencing, editable HH:MM copy,
// field blink, inactivity abort and a one-cycle commit strobe.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int HOUR_MAX      = HOUR_MAX_DEF,
  parameter int MIN_MAX       = MIN_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic               blink_tick,
  input  logic [DIGIT_W-1:0] cur_hh_t,
  input  logic [DIGIT_W-1:0] cur_hh_o,
  input  logic [DIGIT_W-1:0] cur_mm_t,
  input  logic [DIGIT_W-1:0] cur_mm_o,
  output logic [DIGIT_W-1:0] set_hh_t,
  output logic [DIGIT_W-1:0] set_hh_o,
  output logic [DIGIT_W-1:0] set_mm_t,
  output logic [DIGIT_W-1:0] set_mm_o,
  output logic               sel,
  output logic               load,
  output logic               blank_hh,
  output logic               blank_mm
);

  localparam logic [DIGIT_W-1:0] HH_MAX_T = DIGIT_W'(HOUR_MAX / 10);
  localparam logic [DIGIT_W-1:0] HH_MAX_O = DIGIT_W'(HOUR_MAX % 10);
  localparam logic [DIGIT_W-1:0] MM_MAX_T = DIGIT_W'(MIN_MAX / 10);
  localparam logic [DIGIT_W-1:0] MM_MAX_O = DIGIT_W'(MIN_MAX % 10);
  localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT_TICKS - 1);

  // The counter is sized from the package default; reject overrides that overflow it
  if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS >= (1 << TO_W)) begin : g_to_range
    $error("TIMEOUT_TICKS does not fit the timeout counter");
  end

  state_e             state_reg, state_next;
  logic [DIGIT_W-1:0] hh_t_reg, hh_t_next, hh_o_reg, hh_o_next;
  logic [DIGIT_W-1:0] mm_t_reg, mm_t_next, mm_o_reg, mm_o_next;
  logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
  logic               phase_reg, phase_next;
  logic               mode_prev_reg, inc_prev_reg;
  logic               mode_ev, inc_ev;
  logic [DIGIT_W-1:0] hh_inc_t, hh_inc_o, mm_inc_t, mm_inc_o;

  assign mode_ev = btn_mode & ~mode_prev_reg;
  assign inc_ev  = btn_inc & ~inc_prev_reg;

  bcd2_wrap_inc u_hh_inc (
    .tens     (hh_t_reg),
    .ones     (hh_o_reg),
    .max_tens (HH_MAX_T),
    .max_ones (HH_MAX_O),
    .inc_tens (hh_inc_t),
    .inc_ones (hh_inc_o)
  );

  bcd2_wrap_inc u_mm_inc (
    .tens     (mm_t_reg),
    .ones     (mm_o_reg),
    .max_tens (MM_MAX_T),
    .max_ones (MM_MAX_O),
    .inc_tens (mm_inc_t),
    .inc_ones (mm_inc_o)
  );

  always_comb begin
    state_next  = state_reg;
    hh_t_next   = hh_t_reg;
    hh_o_next   = hh_o_reg;
    mm_t_next   = mm_t_reg;
    mm_o_next   = mm_o_reg;
    to_cnt_next = to_cnt_reg;
    phase_next  = phase_reg;
    case (state_reg)
      RUN: begin
        if (mode_ev) begin
          state_next  = SET_HH;
          hh_t_next   = cur_hh_t;
          hh_o_next   = cur_hh_o;
          mm_t_next   = cur_mm_t;
          mm_o_next   = cur_mm_o;
          to_cnt_next = '0;
          phase_next  = 1'b0;
        end
      end
      SET_HH, SET_MM: begin
        // Mode beats inc, and any button edge beats the timeout tick
        if (mode_ev) begin
          state_next  = (state_reg == SET_HH) ? SET_MM : COMMIT;
          to_cnt_next = '0;
          phase_next  = 1'b0;
        end else if (inc_ev) begin
          if (state_reg == SET_HH) begin
            hh_t_next = hh_inc_t;
            hh_o_next = hh_inc_o;
          end else begin
            mm_t_next = mm_inc_t;
            mm_o_next = mm_inc_o;
          end
          to_cnt_next = '0;
          phase_next  = 1'b0;
        end else if (blink_tick) begin
          if (to_cnt_reg == TO_LAST) begin
            state_next  = RUN;
            to_cnt_next = '0;
            phase_next  = 1'b0;
          end else begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
            phase_next  = ~phase_reg;
          end
        end
      end
      COMMIT: begin
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= RUN;
      hh_t_reg      <= '0;
      hh_o_reg      <= '0;
      mm_t_reg      <= '0;
      mm_o_reg      <= '0;
      to_cnt_reg    <= '0;
      phase_reg     <= 1'b0;
      mode_prev_reg <= 1'b0;
      inc_prev_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hh_t_reg      <= hh_t_next;
      hh_o_reg      <= hh_o_next;
      mm_t_reg      <= mm_t_next;
      mm_o_reg      <= mm_o_next;
      to_cnt_reg    <= to_cnt_next;
      phase_reg     <= phase_next;
      mode_prev_reg <= btn_mode;
      inc_prev_reg  <= btn_inc;
    end
  end

  assign set_hh_t = hh_t_reg;
  assign set_hh_o = hh_o_reg;
  assign set_mm_t = mm_t_reg;
  assign set_mm_o = mm_o_reg;
  assign sel      = (state_reg != RUN);
  assign load     = (state_reg == COMMIT);
  assign blank_hh = phase_reg & (state_reg == SET_HH);
  assign blank_mm = phase_reg & (state_reg == SET_MM);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: edit, wrap, held/simultaneous buttons,
// timeout, blink and reset abort, each against hand-computed values.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_inc, blink_tick;
  logic [3:0] cur_hh_t, cur_hh_o, cur_mm_t, cur_mm_o;
  logic [3:0] set_hh_t, set_hh_o, set_mm_t, set_mm_o;
  logic       sel, load, blank_hh, blank_mm;
  logic [15:0] set_val;

  int n_cmp = 0;
  int n_err = 0;
  int load_cnt = 0;
  int base;

  clock_set_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .blink_tick (blink_tick),
    .cur_hh_t   (cur_hh_t),
    .cur_hh_o   (cur_hh_o),
    .cur_mm_t   (cur_mm_t),
    .cur_mm_o   (cur_mm_o),
    .set_hh_t   (set_hh_t),
    .set_hh_o   (set_hh_o),
    .set_mm_t   (set_mm_t),
    .set_mm_o   (set_mm_o),
    .sel        (sel),
    .load       (load),
    .blank_hh   (blank_hh),
    .blank_mm   (blank_mm)
  );

  always #5 clk = ~clk;

  assign set_val = {set_hh_t, set_hh_o, set_mm_t, set_mm_o};

  always @(posedge clk) if (load === 1'b1) load_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step();
    btn_mode = 1'b0; step();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; step();
    btn_inc = 1'b0; step();
  endtask

  task automatic tick();
    blink_tick = 1'b1; step();
    blink_tick = 1'b0; step();
  endtask

  task automatic set_cur(input logic [15:0] v);
    {cur_hh_t, cur_hh_o, cur_mm_t, cur_mm_o} = v;
  endtask

  initial begin
    rst = 1'b0; btn_mode = 1'b1; btn_inc = 1'b1; blink_tick = 1'b0;
    set_cur(16'h1234);

    // Reset with buttons active
    step(); step();
    chk("rst_sel", sel, 0);
    chk("rst_load", load, 0);
    chk("rst_blank", {blank_hh, blank_mm}, 0);
    chk("rst_set", set_val, 16'h0000);
    btn_mode = 1'b0; btn_inc = 1'b0;
    step();
    rst = 1'b1;
    step(); step();
    chk("post_rst_sel", sel, 0);
    chk("post_rst_noload", load_cnt, 0);

    // Full edit 12:34 -> 15:36
    base = load_cnt;
    press_mode();
    chk("edit_capture", set_val, 16'h1234);
    chk("edit_sel", sel, 1);
    press_inc(); press_inc(); press_inc();
    chk("edit_hh", set_val, 16'h1534);
    press_mode();
    press_inc(); press_inc();
    chk("edit_mm", set_val, 16'h1536);
    btn_mode = 1'b1; step();
    chk("commit_load", load, 1);
    chk("commit_val", set_val, 16'h1536);
    btn_mode = 1'b0; step();
    chk("commit_load_off", load, 0);
    chk("commit_sel_off", sel, 0);
    chk("commit_pulses", load_cnt - base, 1);

    // Wrap 23:59 -> 00:00
    set_cur(16'h2359);
    press_mode();
    press_inc();
    chk("wrap_hh", set_val, 16'h0059);
    press_mode();
    press_inc();
    chk("wrap_mm", set_val, 16'h0000);
    press_mode();
    chk("wrap_exit_sel", sel, 0);

    // Held inc, then simultaneous mode+inc in SET_HH
    set_cur(16'h0708);
    press_mode();
    btn_inc = 1'b1;
    repeat (50) step();
    btn_inc = 1'b0; step();
    chk("held_inc", set_val, 16'h0808);
    btn_mode = 1'b1; btn_inc = 1'b1; step();
    chk("simul_hh_kept", set_val, 16'h0808);
    btn_mode = 1'b0; btn_inc = 1'b0; step();
    press_inc();
    chk("simul_in_mm", set_val, 16'h0809);

    // Timeout in SET_MM
    base = load_cnt;
    repeat (19) tick();
    chk("to_19_sel", sel, 1);
    tick();
    chk("to_20_sel", sel, 0);
    chk("to_keep", set_val, 16'h0809);
    chk("to_noload", load_cnt - base, 0);

    // Inc on tick 19 restarts the count
    press_mode(); press_mode();
    repeat (18) tick();
    blink_tick = 1'b1; btn_inc = 1'b1; step();
    blink_tick = 1'b0; btn_inc = 1'b0; step();
    chk("to_inc_val", set_val, 16'h0709);
    tick();
    chk("to_after_inc", sel, 1);
    press_mode();
    chk("to_exit_sel", sel, 0);

    // Blink in SET_HH, inc resets phase, reset aborts SET_MM
    press_mode();
    tick();
    chk("blink1", {blank_hh, blank_mm}, 2'b10);
    tick();
    chk("blink2", {blank_hh, blank_mm}, 2'b00);
    tick();
    chk("blink3", {blank_hh, blank_mm}, 2'b10);
    press_inc();
    chk("blink_inc", {blank_hh, blank_mm}, 2'b00);
    chk("blink_inc_val", set_val, 16'h0808);
    press_mode();
    base = load_cnt;
    rst = 1'b0; step();
    chk("abort_sel", sel, 0);
    chk("abort_load", load, 0);
    rst = 1'b1; step(); step();
    chk("abort_set", set_val, 16'h0000);
    chk("abort_noload", load_cnt - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
